// File: rtl/fp_add_arbiter.sv
// fp_add_arbiter: shares one pipelined FP adder among NREQ requesters,
// round-robin grant, tag FIFO routes sums back. Option macro: FP_ARB_PRIO_EN.
module fp_add_arbiter #(
  parameter int PRECISION = 32,
  parameter int NREQ      = 4,
  parameter int TAG_DEPTH = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ*PRECISION-1:0] req_a,
  input  logic [NREQ*PRECISION-1:0] req_b,
  output logic [NREQ-1:0]           req_ready,
  output logic [NREQ-1:0]           rsp_valid,
  output logic [PRECISION-1:0]      rsp_data,
  output logic                      add_tvalid,
  output logic [PRECISION-1:0]      add_a,
  output logic [PRECISION-1:0]      add_b,
  input  logic                      add_result_valid,
  input  logic [PRECISION-1:0]      add_result,
  output logic                      busy,
  output logic                      tag_err
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int AW = $clog2(TAG_DEPTH);
  localparam int CW = AW + 1;

  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] tag_mem [TAG_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;
  logic          full_q;

  logic [IW-1:0] win;
  logic          win_ok;
  logic          grant;
  logic          pop;
  int            base;
  int            idx;

  // Winner search: first pending requester at or after rr_ptr.
  // Scanning backwards lets the nearest candidate overwrite the rest.
  always_comb begin
    win    = '0;
    win_ok = 1'b0;
    base   = 0;
    idx    = 0;
`ifdef FP_ARB_PRIO_EN
    base = (rr_ptr == '0) ? 0 : int'(rr_ptr) - 1;
    if (req_valid[0]) begin
      win_ok = 1'b1;
    end else begin
      for (int i = NREQ - 2; i >= 0; i--) begin
        idx = 1 + ((base + i) % (NREQ - 1));
        if (req_valid[idx]) begin
          win    = IW'(idx);
          win_ok = 1'b1;
        end
      end
    end
`else
    base = int'(rr_ptr);
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = (base + i) % NREQ;
      if (req_valid[idx]) begin
        win    = IW'(idx);
        win_ok = 1'b1;
      end
    end
`endif
  end

  // Full is a registered flag, so a pop never frees a slot the same cycle.
  assign grant = win_ok && !full_q && !reset;
  assign pop   = add_result_valid && (count != '0);

  // One-hot grant of the winner.
  always_comb begin
    req_ready = '0;
    if (grant) req_ready[win] = 1'b1;
  end

  // Occupancy after this cycle's push/pop.
  always_comb begin
    count_nxt = count + CW'(grant) - CW'(pop);
  end

  // Tag storage needs no reset; pointers define what is live.
  always_ff @(posedge clk) begin
    if (grant) tag_mem[wr_ptr] <= win;
  end

  // Pointers, flags, adder issue and response routing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr     <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      full_q     <= 1'b0;
      busy       <= 1'b0;
      tag_err    <= 1'b0;
      add_tvalid <= 1'b0;
      add_a      <= '0;
      add_b      <= '0;
      rsp_valid  <= '0;
      rsp_data   <= '0;
    end else begin
      count      <= count_nxt;
      full_q     <= (count_nxt == CW'(TAG_DEPTH));
      busy       <= (count_nxt != '0);
      add_tvalid <= grant;
      rsp_valid  <= '0;
      if (grant) begin
        wr_ptr <= wr_ptr + AW'(1);
        add_a  <= req_a[win*PRECISION +: PRECISION];
        add_b  <= req_b[win*PRECISION +: PRECISION];
`ifdef FP_ARB_PRIO_EN
        if (win != '0)
          rr_ptr <= IW'((int'(win) + 1) % NREQ);
`else
        rr_ptr <= IW'((int'(win) + 1) % NREQ);
`endif
      end
      if (pop) begin
        rd_ptr    <= rd_ptr + AW'(1);
        rsp_valid <= NREQ'(1) << tag_mem[rd_ptr];
        rsp_data  <= add_result;
      end
      if (add_result_valid && (count == '0))
        tag_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fp_add_arbiter.sv
// tb_fp_add_arbiter: random + directed traffic against a pipelined
// integer-valued FP adder model; scoreboard checks routed sums.
module tb_fp_add_arbiter;

  localparam int P = 32;
  localparam int N = 4;
  localparam int D = 16;
  localparam int L = 11;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N*P-1:0] req_a = '0;
  logic [N*P-1:0] req_b = '0;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   rsp_valid;
  logic [P-1:0]   rsp_data;
  logic           add_tvalid;
  logic [P-1:0]   add_a;
  logic [P-1:0]   add_b;
  logic           add_result_valid = 1'b0;
  logic [P-1:0]   add_result = '0;
  logic           busy;
  logic           tag_err;

  fp_add_arbiter #(.PRECISION(P), .NREQ(N), .TAG_DEPTH(D)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .add_tvalid(add_tvalid), .add_a(add_a), .add_b(add_b),
    .add_result_valid(add_result_valid), .add_result(add_result),
    .busy(busy), .tag_err(tag_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int id; logic [31:0] sum; int t; } exp_t;
  typedef struct { logic [31:0] r; int due; } pipe_t;

  int     n_cmp = 0;
  int     n_bad = 0;
  exp_t   sbq[$];
  pipe_t  aq[$];
  int     grants[$];

  logic [N-1:0] pv = '0;
  int     pa[N];
  int     pb[N];
  logic [N-1:0] gen_mask = '0;
  int     budget = 0;
  int     gen_pct = 100;
  bit     stall = 0;
  int     rel_cnt = 0;
  bit     inject = 0;
  bit     lat_chk = 1;

  // reference state, in terms of the arbitration rules
  int     mptr = 0;
  int     mocc = 0;
  bit     mfull = 0;
  bit     merr = 0;
  bit     mbusy = 0;
  bit     exp_tv = 0;
  logic [31:0] exp_a = '0;
  logic [31:0] exp_b = '0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] i2f(int v);
    int m;
    int e;
    logic [31:0] r;
    if (v == 0) return 32'h0;
    m = (v < 0) ? -v : v;
    e = 0;
    while ((m >> (e + 1)) != 0) e++;
    r[31]    = (v < 0);
    r[30:23] = 8'(127 + e);
    r[22:0]  = 23'((m << (23 - e)) & 32'h7FFFFF);
    return r;
  endfunction

  function automatic int f2i(logic [31:0] f);
    int e;
    int m;
    int v;
    if (f[30:23] == 8'd0) return 0;
    e = int'(f[30:23]) - 127;
    if (e < 0 || e > 23) return 0;
    m = int'({1'b1, f[22:0]});
    v = m >> (23 - e);
    return f[31] ? -v : v;
  endfunction

  // Which requester should win: walk from the pointer, wrapping.
  function automatic int exp_win(logic [N-1:0] v, int p);
`ifdef FP_ARB_PRIO_EN
    if (v[0]) return 0;
    for (int k = 0; k < N; k++) begin
      int j;
      j = (p + k) % N;
      if (j != 0 && v[j]) return j;
    end
`else
    for (int k = 0; k < N; k++) begin
      int j;
      j = (p + k) % N;
      if (v[j]) return j;
    end
`endif
    return -1;
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_a[i*P +: P] = i2f(pa[i]);
      req_b[i*P +: P] = i2f(pb[i]);
    end
    req_valid = pv;
  endtask

  task automatic model_clear();
    mptr = 0; mocc = 0; mfull = 0; merr = 0; mbusy = 0; exp_tv = 0;
    sbq.delete();
    pv = '0;
  endtask

  // One clock: drive at the falling edge, sample 2ns later.
  task automatic step();
    int g;
    int gi;
    bit popd;
    logic [N-1:0] ex;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      if (!pv[i] && gen_mask[i] && budget != 0 &&
          $urandom_range(99) < gen_pct) begin
        pa[i] = int'($urandom_range(2000)) - 1000;
        pb[i] = int'($urandom_range(2000)) - 1000;
        pv[i] = 1'b1;
        if (budget > 0) budget--;
      end
    end
    drive();
    add_result_valid = 1'b0;
    if (inject) begin
      add_result_valid = 1'b1;
      add_result = $urandom;
      inject = 0;
    end else if (aq.size() > 0 && aq[0].due <= cyc &&
                 (!stall || rel_cnt > 0)) begin
      add_result_valid = 1'b1;
      add_result = aq[0].r;
      void'(aq.pop_front());
      if (stall) rel_cnt--;
    end
    #2;
    if (reset) return;
    g = exp_win(pv, mptr);
    ex = '0;
    if (g >= 0 && !mfull) ex[g] = 1'b1;
    chk("req_ready", req_ready, ex);
    chk("busy", busy, mbusy);
    chk("tag_err", tag_err, merr);
    chk("add_tvalid", add_tvalid, exp_tv);
    if (exp_tv) begin
      chk("add_a", add_a, exp_a);
      chk("add_b", add_b, exp_b);
    end
    if (add_tvalid === 1'b1)
      aq.push_back('{i2f(f2i(add_a) + f2i(add_b)), cyc + L});
    gi = -1;
    for (int i = 0; i < N; i++)
      if (pv[i] && req_ready[i]) gi = i;
    exp_tv = (gi >= 0);
    if (gi >= 0) begin
      sbq.push_back('{gi, i2f(pa[gi] + pb[gi]), cyc});
      exp_a = i2f(pa[gi]);
      exp_b = i2f(pb[gi]);
      pv[gi] = 1'b0;
      grants.push_back(gi);
`ifdef FP_ARB_PRIO_EN
      if (gi != 0) mptr = (gi + 1) % N;
`else
      mptr = (gi + 1) % N;
`endif
    end
    popd = add_result_valid && (mocc > 0);
    if (add_result_valid && mocc == 0) merr = 1;
    mocc = mocc + (gi >= 0 ? 1 : 0) - (popd ? 1 : 0);
    mfull = (mocc == D);
    mbusy = (mocc != 0);
  endtask

  task automatic chk_zero(string nm);
    chk({nm, "_req_ready"}, req_ready, 0);
    chk({nm, "_rsp_valid"}, rsp_valid, 0);
    chk({nm, "_rsp_data"}, rsp_data, 0);
    chk({nm, "_add_tvalid"}, add_tvalid, 0);
    chk({nm, "_add_a"}, add_a, 0);
    chk({nm, "_add_b"}, add_b, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_tag_err"}, tag_err, 0);
  endtask

  task automatic do_reset(int n);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk_zero("reset");
    model_clear();
    gen_mask = '0;
    budget = 0;
    drive();
    repeat (n) step();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic drain(string nm);
    int k;
    budget = 0;
    stall = 0;
    k = 0;
    while ((sbq.size() != 0 || pv != '0 || aq.size() != 0) && k < 400) begin
      step();
      k++;
    end
    repeat (2) step();
    chk({nm, "_drained"}, sbq.size(), 0);
  endtask

  // Response monitor: pops the scoreboard whenever a result is routed.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (!reset && rsp_valid !== '0) begin
        if (sbq.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL rsp_unexpected: got rsp_valid %b, expected none (cycle %0d)",
                   rsp_valid, cyc);
        end else begin
          e = sbq.pop_front();
          chk("rsp_valid", rsp_valid, 64'(1) << e.id);
          chk("rsp_data", rsp_data, e.sum);
          if (lat_chk) chk("rsp_latency", cyc, e.t + 2 + L);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected completion");
    $fatal(1);
  end

  initial begin
    int g0;
    for (int i = 0; i < N; i++) begin pa[i] = 0; pb[i] = 0; end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk_zero("por");
    @(negedge clk);
    reset = 1'b0;

    // single op from requester 1: 1.0 + 2.0
    grants.delete();
    pa[1] = 1; pb[1] = 2; pv[1] = 1'b1;
    chk("t1_sum_model", i2f(pa[1] + pb[1]), 32'h40400000);
    drain("t1");
    chk("t1_grants", grants.size(), 1);
    if (grants.size() > 0) chk("t1_who", grants[0], 1);

    // all four held valid from reset for 8 grants
    do_reset(3);
    grants.delete();
    gen_mask = '1; gen_pct = 100; budget = 8;
    repeat (10) step();
    chk("t2_count", grants.size(), 8);
    for (int k = 0; k < 8 && k < grants.size(); k++)
      chk("t2_order", grants[k], k % 4);
    drain("t2");
    chk("t2_busy_low", busy, 0);

    // stalled adder: fill the tag FIFO, then free one slot
    grants.delete();
    lat_chk = 0;
    stall = 1; rel_cnt = 0;
    gen_mask = '1; budget = -1;
    repeat (30) step();
    chk("t3_fill", grants.size(), D);
    rel_cnt = 1;
    repeat (6) step();
    chk("t3_refill", grants.size(), D + 1);
    gen_mask = '0;
    drain("t3");
    lat_chk = 1;

    // result with nothing in flight
    inject = 1;
    repeat (4) step();
    chk("t4_tag_err", tag_err, 1);
    repeat (5) step();
    chk("t4_sticky", tag_err, 1);

    // reset with 3 ops in flight, held 12 cycles
    grants.delete();
    gen_mask = '1; budget = 3;
    repeat (5) step();
    g0 = grants.size();
    chk("t5_inflight", g0, 3);
    do_reset(12);
    step();
    chk("t5_tag_err", tag_err, 0);
    pa[2] = 7; pb[2] = -20; pv[2] = 1'b1;
    drain("t5");

    // randomized traffic
    gen_mask = '1; gen_pct = 40; budget = 200;
    while (budget != 0) step();
    drain("rand");

`ifdef FP_ARB_PRIO_EN
    do_reset(3);
    grants.delete();
    gen_mask = '1; gen_pct = 100; budget = -1;
    repeat (8) step();
    for (int k = 0; k < 8 && k < grants.size(); k++)
      chk("t6_prio0", grants[k], 0);
    gen_mask = 4'b1110;
    grants.delete();
    repeat (9) step();
    chk("t6_count", grants.size(), 9);
    for (int k = 0; k < grants.size(); k++)
      chk("t6_rr", grants[k], 1 + (k % 3));
    gen_mask = '0;
    drain("t6");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
